// File: rtl/axi4_lite_regs_pkg.sv
// Shared types and constants for the AXI4-Lite register bank.
// The optional byte-strobe feature is selected by AXI4_LITE_REGS_WSTRB_EN.
package axi4_lite_regs_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned IDX_WIDTH = 8;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

  function automatic logic idx_in_range(input logic [IDX_WIDTH-1:0] idx,
                                        input int unsigned num_regs);
    return ({1'b0, idx} < 9'(num_regs));
  endfunction

endpackage

// File: rtl/axi4_lite_regs_if.sv
// AXI4-Lite bus bundle between a master and the register bank.
interface axi4_lite_regs_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axi4_lite_wr_join.sv
// Joins the AW and W channels in either order and emits a commit pulse for the
// cycle whose closing edge enters W_RESP, with the address/data/strobe to commit.
module axi4_lite_wr_join
  import axi4_lite_regs_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    commit
);

  wr_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] strb_q;

  logic aw_hs, w_hs;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= W_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) state_d = W_RESP;
        else if (aw_hs)    state_d = W_HAVE_A;
        else if (w_hs)     state_d = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)             state_d = W_RESP;
      W_HAVE_D: if (aw_hs)            state_d = W_RESP;
      W_RESP:   if (bvalid && bready) state_d = W_IDLE;
      default:                        state_d = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (state_q)
      W_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
      end
      W_HAVE_A: wready  = 1'b1;
      W_HAVE_D: awready = 1'b1;
      W_RESP:   bvalid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      if (aw_hs) addr_q <= awaddr;
      if (w_hs) begin
        data_q <= wdata;
        strb_q <= wstrb;
      end
    end
  end

  // Whichever half arrived earlier comes from the capture register, the other from the bus.
  assign commit  = (state_q != W_RESP) && (state_d == W_RESP);
  assign wr_addr = (state_q == W_HAVE_A) ? addr_q : awaddr;
  assign wr_data = (state_q == W_HAVE_D) ? data_q : wdata;
  assign wr_strb = (state_q == W_HAVE_D) ? strb_q : wstrb;

endmodule

// File: rtl/axi4_lite_regs_bank.sv
// AXI4-Lite slave exposing NUM_REGS registers with independent read and write paths.
// Define AXI4_LITE_REGS_WSTRB_EN to honour WSTRB byte lanes; otherwise full words are written.
module axi4_lite_regs_bank
  import axi4_lite_regs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8,
  parameter logic [31:0] RESET_BASE = 32'h00007700
) (
  input logic              ACLK,
  input logic              ARESETN,
  axi4_lite_regs_if.slave  bus
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_LSB    = $clog2(STRB_WIDTH);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Write path
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  commit;
  logic                  awready, wready, bvalid;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic                  wr_in_range;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [1:0]            bresp_q;

  axi4_lite_wr_join #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_join (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .awaddr  (bus.AWADDR),
    .awvalid (bus.AWVALID),
    .awready (awready),
    .wdata   (bus.WDATA),
    .wstrb   (bus.WSTRB),
    .wvalid  (bus.WVALID),
    .wready  (wready),
    .bvalid  (bvalid),
    .bready  (bus.BREADY),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .commit  (commit)
  );

  assign wr_idx      = wr_addr[IDX_LSB +: IDX_WIDTH];
  assign wr_in_range = idx_in_range(wr_idx, NUM_REGS);

  always_comb begin
    wr_mask = '1;
`ifdef AXI4_LITE_REGS_WSTRB_EN
    for (int b = 0; b < int'(STRB_WIDTH); b++) begin
      wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
    end
`endif
  end

  // An out-of-range index matches no register, so nothing is written.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= DATA_WIDTH'(RESET_BASE + 32'(i));
      end
    end else if (commit) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (wr_idx == IDX_WIDTH'(i)) begin
          regs_q[i] <= (regs_q[i] & ~wr_mask) | (wr_data & wr_mask);
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bresp_q <= RESP_OKAY;
    end else if (commit) begin
      bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BRESP   = bresp_q;

  // Read path
  rd_state_e             rd_state_q, rd_state_d;
  logic                  arready, rvalid, ar_hs;
  logic [IDX_WIDTH-1:0]  rd_idx;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  assign ar_hs       = bus.ARVALID && arready;
  assign rd_idx      = bus.ARADDR[IDX_LSB +: IDX_WIDTH];
  assign rd_in_range = idx_in_range(rd_idx, NUM_REGS);

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rd_idx == IDX_WIDTH'(i)) rd_val = regs_q[i];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q <= R_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      R_IDLE:  if (ar_hs)       rd_state_d = R_RESP;
      R_RESP:  if (bus.RREADY)  rd_state_d = R_IDLE;
      default:                  rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (rd_state_q)
      R_IDLE:  arready = 1'b1;
      R_RESP:  rvalid  = 1'b1;
      default: ;
    endcase
  end

  // Sampling regs_q here yields the pre-write value when a commit lands on the same edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_in_range ? rd_val : '0;
      rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign bus.ARREADY = arready;
  assign bus.RVALID  = rvalid;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;

  logic unused_bits;
  assign unused_bits = ^{wr_addr, wr_strb, bus.ARADDR};

endmodule
